// File: rtl/sum_decimator_pkg.sv
// Shared sizing helpers for the sum decimator and other decimating paths.
package sum_decimator_pkg;

  // Default widths of the DSBPM amplitude path.
  localparam int IN_WIDTH_DEF  = 20;
  localparam int CNT_WIDTH_DEF = 10;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int SHIFT_W_DEF   = 5;

  // Accumulator width: a full window of 2^cnt_w extreme samples cannot overflow.
  function automatic int acc_width(input int in_w, input int cnt_w);
    return in_w + cnt_w;
  endfunction

  // Shifts at or beyond the accumulator width collapse to the widest meaningful shift.
  function automatic int clamp_shift(input int sh, input int acc_w);
    return (sh >= acc_w) ? (acc_w - 1) : sh;
  endfunction

  // Largest and smallest values representable in a signed w-bit result.
  function automatic longint out_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint OUT_MAX_DEF = out_max(OUT_WIDTH_DEF);
  localparam longint OUT_MIN_DEF = out_min(OUT_WIDTH_DEF);

endpackage

// File: rtl/sum_decimator_round_sat.sv
// Round-half-up divide by 2^shift followed by saturation to OUT_WIDTH.
// Three registered steps: bias add, arithmetic shift, clip. The result is a
// valid-only stream (no backpressure): valid_out pulses once per accepted
// valid_in, data_out/sat_out hold their last value between pulses.
module sum_decimator_round_sat
  import sum_decimator_pkg::*;
#(
  parameter int ACC_W     = 30,
  parameter int SHIFT_W   = 5,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [ACC_W-1:0]     sum_in,
  input  logic        [SHIFT_W-1:0]   shift_in,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        valid_out,
  output logic                        sat_out
);

  // One extra bit so adding the rounding bias to a near-full-scale sum cannot wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0]     MAX_EXT = EXT_W'(out_max(OUT_WIDTH));
  localparam logic signed [EXT_W-1:0]     MIN_EXT = EXT_W'(out_min(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] MAX_OUT = OUT_WIDTH'(out_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] MIN_OUT = OUT_WIDTH'(out_min(OUT_WIDTH));

  logic        [SHIFT_W-1:0]   sh_eff;
  logic signed [EXT_W-1:0]     sum_ext;
  logic signed [EXT_W-1:0]     bias;
  logic signed [EXT_W-1:0]     biased_q;
  logic        [SHIFT_W-1:0]   sh_q;
  logic                        va_q;
  logic signed [EXT_W-1:0]     shifted_q;
  logic                        vb_q;
  logic signed [OUT_WIDTH-1:0] clip_val;
  logic                        clip_flag;

  // Clamp the shift and form the half-LSB rounding bias for the requested shift.
  always_comb begin
    sh_eff  = SHIFT_W'(clamp_shift(int'(shift_in), ACC_W));
    sum_ext = {sum_in[ACC_W-1], sum_in};
    bias    = '0;
    if (sh_eff != '0) begin
      bias = EXT_W'(1) << (sh_eff - 1'b1);
    end
  end

  // Step 1: add the rounding bias and carry the clamped shift alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      biased_q <= '0;
      sh_q     <= '0;
      va_q     <= 1'b0;
    end else begin
      va_q <= valid_in;
      if (valid_in) begin
        biased_q <= sum_ext + bias;
        sh_q     <= sh_eff;
      end
    end
  end

  // Step 2: arithmetic right shift; with the bias this rounds half toward +inf.
  always_ff @(posedge clk) begin
    if (rst) begin
      shifted_q <= '0;
      vb_q      <= 1'b0;
    end else begin
      vb_q <= va_q;
      if (va_q) begin
        shifted_q <= biased_q >>> sh_q;
      end
    end
  end

  // Clip decision for the shifted value.
  always_comb begin
    clip_val  = shifted_q[OUT_WIDTH-1:0];
    clip_flag = 1'b0;
    if (shifted_q > MAX_EXT) begin
      clip_val  = MAX_OUT;
      clip_flag = 1'b1;
    end else if (shifted_q < MIN_EXT) begin
      clip_val  = MIN_OUT;
      clip_flag = 1'b1;
    end
  end

  // Step 3: register the saturated result; outputs hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      sat_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= vb_q;
      if (vb_q) begin
        data_out <= clip_val;
        sat_out  <= clip_flag;
      end
    end
  end

endmodule

// File: rtl/sum_decimator.sv
// Windowed accumulate-and-decimate of the adder-tree sum stream.
// Input is a valid-only stream: a sample is consumed on every clk edge where
// valid_in is high, gaps of any length are allowed and there is no ready.
// Window length and shift are captured on the first sample of each window.
module sum_decimator
  import sum_decimator_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic        [CNT_WIDTH:0]   acc_len,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        valid_out,
  output logic                        sat_out
);

  localparam int ACC_W = acc_width(IN_WIDTH, CNT_WIDTH);
  localparam int LEN_W = CNT_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << CNT_WIDTH;

  logic        [LEN_W-1:0]   count_q;
  logic        [LEN_W-1:0]   len_q;
  logic        [SHIFT_W-1:0] shift_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic                      first;
  logic        [LEN_W-1:0]   len_req;
  logic        [LEN_W-1:0]   len_eff;
  logic        [SHIFT_W-1:0] shift_eff;
  logic        [LEN_W-1:0]   count_inc;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   sum_next;
  logic                      last;

  logic                      s1_valid;
  logic signed [ACC_W-1:0]   s1_sum;
  logic        [SHIFT_W-1:0] s1_shift;

  // Window bookkeeping: a sample arriving with count==0 opens a window and uses
  // the live controls; later samples use the values captured at window start.
  always_comb begin
    first   = (count_q == '0);
    len_req = acc_len;
    if (acc_len == '0) begin
      len_req = LEN_W'(1);
    end else if (acc_len > MAX_LEN) begin
      len_req = MAX_LEN;
    end
    len_eff    = first ? len_req : len_q;
    shift_eff  = first ? shift : shift_q;
    count_inc  = count_q + LEN_W'(1);
    sample_ext = {{CNT_WIDTH{data_in[IN_WIDTH-1]}}, data_in};
    sum_next   = acc_q + sample_ext;
    last       = valid_in && (count_inc == len_eff);
  end

  // Accumulator and counter; they clear on the closing sample so the very next
  // valid sample starts a fresh window without a dead cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      len_q   <= LEN_W'(1);
      shift_q <= '0;
      acc_q   <= '0;
    end else if (valid_in) begin
      if (first) begin
        len_q   <= len_req;
        shift_q <= shift;
      end
      if (last) begin
        acc_q   <= '0;
        count_q <= '0;
      end else begin
        acc_q   <= sum_next;
        count_q <= count_inc;
      end
    end
  end

  // S1: capture the completed window sum with the shift it was opened with.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= last;
      if (last) begin
        s1_sum   <= sum_next;
        s1_shift <= shift_eff;
      end
    end
  end

  sum_decimator_round_sat #(
    .ACC_W     (ACC_W),
    .SHIFT_W   (SHIFT_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (s1_valid),
    .sum_in    (s1_sum),
    .shift_in  (s1_shift),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sat_out   (sat_out)
  );

endmodule
